// File: rtl/time_set_ctrl.sv
// time_set_ctrl: BCD time-setting controller; loads a time snapshot, steps the selected field
// up/down with wrap, and pulses commit on exit. Optional macro TIME_SET_AUTOREPEAT_EN adds
// hold-to-repeat stepping on the inc/dec keys.
module time_set_ctrl #(
    parameter int HAS_SEC    = 1,
    parameter int HOUR_12    = 0,
    parameter int REPEAT_DLY = 25_000_000,
    parameter int REPEAT_PER = 5_000_000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       set_en,
    input  logic       key_inc,
    input  logic       key_dec,
    input  logic       key_sel,
    input  logic [7:0] init_hour,
    input  logic [7:0] init_min,
    input  logic [7:0] init_sec,
    output logic [7:0] hour_load,
    output logic [7:0] min_load,
    output logic [7:0] sec_load,
    output logic [1:0] field_sel,
    output logic       commit
);
    localparam logic [7:0] H_LO  = (HOUR_12 != 0) ? 8'h01 : 8'h00;
    localparam logic [7:0] H_HI  = (HOUR_12 != 0) ? 8'h12 : 8'h23;
    localparam logic [7:0] H_RST = (HOUR_12 != 0) ? 8'h12 : 8'h00;

    // The repeat counter reloads to REPEAT_DLY - REPEAT_PER, so the period must not exceed the delay.
    if (REPEAT_DLY < 1 || REPEAT_PER < 1 || REPEAT_PER > REPEAT_DLY) begin : g_bad_repeat
        $error("time_set_ctrl: need 1 <= REPEAT_PER <= REPEAT_DLY");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, HOUR = 2'd1, MIN = 2'd2, SEC = 2'd3} state_t;

    state_t     state;
    logic [2:0] key_q, key_qq;
    logic [2:0] ev;
    logic       rep, go_inc, go_dec, do_inc, do_dec;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        return (v == hi) ? lo : (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        return (v == lo) ? hi : (v[3:0] == 4'h0) ? {v[7:4] - 4'h1, 4'h9} : v - 8'h01;
    endfunction

    function automatic logic [7:0] fix(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        return (v[3:0] <= 4'h9 && v >= lo && v <= hi) ? v : lo;
    endfunction

    // Keys are {sel, dec, inc}; a rising edge of the synchronised level is one event.
    assign ev     = key_q & ~key_qq;
    assign go_inc = ev[0] | (rep & key_q[0]);
    assign go_dec = ev[1] | (rep & key_q[1]);
    assign do_inc = go_inc & ~go_dec & ~ev[2];
    assign do_dec = go_dec & ~go_inc & ~ev[2];
    assign field_sel = state;

    // Two-stage key history for edge detection.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q  <= 3'b000;
            key_qq <= 3'b000;
        end else begin
            key_q  <= {key_sel, key_dec, key_inc};
            key_qq <= key_q;
        end
    end

`ifdef TIME_SET_AUTOREPEAT_EN
    logic [31:0] hold_cnt;
    logic        hold;
    assign hold = (key_q[0] ^ key_q[1]) && state != IDLE && set_en;
    assign rep  = hold && hold_cnt == 32'(REPEAT_DLY - 1);
    // Hold counter: first repeat after REPEAT_DLY cycles, then every REPEAT_PER cycles.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= 32'd0;
        else if (!hold || ev[2])
            hold_cnt <= 32'd0;
        else
            hold_cnt <= rep ? 32'(REPEAT_DLY - REPEAT_PER) : hold_cnt + 32'd1;
    end
`else
    assign rep = 1'b0;
`endif

    // Mode FSM with snapshot load, field stepping and commit pulse.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hour_load <= H_RST;
            min_load  <= 8'h00;
            sec_load  <= 8'h00;
            commit    <= 1'b0;
        end else begin
            commit <= 1'b0;
            if (state == IDLE) begin
                if (set_en) begin
                    state     <= HOUR;
                    hour_load <= fix(init_hour, H_LO, H_HI);
                    min_load  <= fix(init_min, 8'h00, 8'h59);
                    sec_load  <= (HAS_SEC != 0) ? fix(init_sec, 8'h00, 8'h59) : 8'h00;
                end
            end else if (!set_en) begin
                state  <= IDLE;
                commit <= 1'b1;
            end else if (ev[2]) begin
                state <= (state == HOUR) ? MIN : (state == MIN && HAS_SEC != 0) ? SEC : HOUR;
            end else if (do_inc || do_dec) begin
                if (state == HOUR)
                    hour_load <= do_inc ? bcd_inc(hour_load, H_LO, H_HI) : bcd_dec(hour_load, H_LO, H_HI);
                if (state == MIN)
                    min_load <= do_inc ? bcd_inc(min_load, 8'h00, 8'h59) : bcd_dec(min_load, 8'h00, 8'h59);
                if (state == SEC)
                    sec_load <= do_inc ? bcd_inc(sec_load, 8'h00, 8'h59) : bcd_dec(sec_load, 8'h00, 8'h59);
            end
        end
    end
endmodule
